// File: rtl/aqed_fifo_fc_checker_if.sv
// Handshake bundle between the A-QED FIFO checker, the BMC stimulus and the
// memory_core FIFO under test.  slave = checker view, master = environment view.
interface aqed_fifo_fc_checker_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
);
   logic [DATA_WIDTH-1:0] bmc_in_data;
   logic                  bmc_in_v;
   logic                  orig_sel;
   logic                  dup_sel;
   logic                  dut_full;
   logic                  dut_empty;
   logic [DATA_WIDTH-1:0] dut_data_out;
   logic                  dut_valid_out;
   logic [DATA_WIDTH-1:0] dut_data_in;
   logic                  dut_wen;
   logic                  dut_ren;
   logic                  qed_done;
   logic                  qed_check;
   logic [CNT_WIDTH-1:0]  seq_pointer;

   modport slave (
      input  bmc_in_data, bmc_in_v, orig_sel, dup_sel,
      input  dut_full, dut_empty, dut_data_out, dut_valid_out,
      output dut_data_in, dut_wen, dut_ren, qed_done, qed_check, seq_pointer
   );

   modport master (
      output bmc_in_data, bmc_in_v, orig_sel, dup_sel,
      output dut_full, dut_empty, dut_data_out, dut_valid_out,
      input  dut_data_in, dut_wen, dut_ren, qed_done, qed_check, seq_pointer
   );
endinterface

// File: rtl/aqed_fifo_fc_checker.sv
// A-QED functional-consistency checker for FIFO-mode memory_core.
// Forwards solver writes, drains reads, tags an original and a later
// duplicate write of the same data and compares their read-back values.
// Optional bounded-response check: define AQED_BC_EN.
module aqed_fifo_fc_checker #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8,
   parameter int READ_LAT   = 1,
   parameter int RESP_BOUND = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   aqed_fifo_fc_checker_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ORIG, DUP, DONE} state_t;

   typedef struct packed {
      logic [CNT_WIDTH-1:0]  idx;
      logic [DATA_WIDTH-1:0] data;
   } tag_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                state;
   logic [CNT_WIDTH-1:0]  wr_cnt;
   logic [CNT_WIDTH-1:0]  rd_cnt;
   logic [CNT_WIDTH-1:0]  dup_idx;
   tag_t                  orig;
   logic [DATA_WIDTH-1:0] orig_out;
   logic                  orig_out_v;
   logic                  qed_done_q;
   logic                  qed_check_q;
   // vld_pipe tracks the orig write in flight; its read-back cannot show up
   // before READ_LAT cycles after the FIFO could first present it.
   logic [READ_LAT:0]     vld_pipe;
   logic                  orig_armed;

   logic live, acc, wr_sat, rd_sat;
   logic take_orig, take_dup, orig_hit, dup_hit;

`ifdef AQED_BC_EN
   localparam int BC_W = $clog2(RESP_BOUND + 1);
   logic [BC_W-1:0] cnt_bc;
`else
   // RESP_BOUND only takes effect with the bound check compiled in.
   if (RESP_BOUND < 1) begin : g_bound_unused
   end
`endif

   // Accept/read gating and tag/match decisions for this cycle.
   always_comb begin
      live      = reset & (state != DONE);
      acc       = bus.bmc_in_v & ~bus.dut_full & live;
      wr_sat    = (wr_cnt == CNT_MAX);
      rd_sat    = (rd_cnt == CNT_MAX);
      take_orig = acc & bus.orig_sel & ~wr_sat & (state == IDLE);
      take_dup  = acc & bus.dup_sel & ~bus.orig_sel & ~wr_sat & (state == ORIG)
                & (bus.bmc_in_data == orig.data);
      orig_hit  = bus.dut_valid_out & (rd_cnt == orig.idx)
                & ((state == ORIG) | (state == DUP))
                & (orig_armed | vld_pipe[READ_LAT]);
      dup_hit   = bus.dut_valid_out & (rd_cnt == dup_idx) & (state == DUP);
   end

   assign bus.dut_wen     = acc;
   assign bus.dut_ren     = ~bus.dut_empty & live;
   assign bus.dut_data_in = bus.bmc_in_data;
   assign bus.seq_pointer = wr_cnt;
   assign bus.qed_done    = qed_done_q;
   assign bus.qed_check   = qed_check_q;

   // Counters, tag capture and the IDLE->ORIG->DUP->DONE sequence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         dup_idx     <= '0;
         orig        <= '0;
         orig_out    <= '0;
         orig_out_v  <= 1'b0;
         qed_done_q  <= 1'b0;
         qed_check_q <= 1'b0;
         vld_pipe    <= '0;
         orig_armed  <= 1'b0;
`ifdef AQED_BC_EN
         cnt_bc      <= '0;
`endif
      end else begin
         if (acc && !wr_sat)
            wr_cnt <= wr_cnt + CNT_WIDTH'(1);
         if (bus.dut_valid_out && !rd_sat)
            rd_cnt <= rd_cnt + CNT_WIDTH'(1);

         vld_pipe[0] <= take_orig;
         for (int i = 1; i <= READ_LAT; i++)
            vld_pipe[i] <= vld_pipe[i-1];
         if (vld_pipe[READ_LAT])
            orig_armed <= 1'b1;

         if (orig_hit) begin
            orig_out   <= bus.dut_data_out;
            orig_out_v <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (take_orig) begin
                  orig  <= '{idx: wr_cnt, data: bus.bmc_in_data};
                  state <= ORIG;
               end
            end
            ORIG: begin
               if (take_dup) begin
                  dup_idx <= wr_cnt;
                  state   <= DUP;
`ifdef AQED_BC_EN
                  cnt_bc  <= '0;
`endif
               end
            end
            DUP: begin
               if (dup_hit) begin
                  state       <= DONE;
                  qed_done_q  <= 1'b1;
                  qed_check_q <= orig_out_v & (bus.dut_data_out == orig_out);
               end
`ifdef AQED_BC_EN
               else if (cnt_bc == BC_W'(RESP_BOUND)) begin
                  // Duplicate never came back in time: liveness failure.
                  state       <= DONE;
                  qed_done_q  <= 1'b1;
                  qed_check_q <= 1'b0;
               end else begin
                  cnt_bc <= cnt_bc + BC_W'(1);
               end
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aqed_fifo_fc_checker.sv
// Bench for aqed_fifo_fc_checker: a queue-based FIFO stands in for the
// memory_core, and a tag/index reference model predicts the checker outputs.
// Bounded-response scenario is exercised when AQED_BC_EN is defined.
module tb_aqed_fifo_fc_checker;
   localparam int DW     = 8;
   localparam int CW     = 4;
   localparam int RL     = 1;
   localparam int RB     = 8;
   localparam int FDEPTH = 4;
   localparam int MAXC   = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aqed_fifo_fc_checker_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   aqed_fifo_fc_checker #(
      .DATA_WIDTH(DW), .CNT_WIDTH(CW), .READ_LAT(RL), .RESP_BOUND(RB)
   ) dut (
      .clk(clk), .reset(rst_n), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // environment FIFO
   logic [DW-1:0] fq[$];
   bit            env_v;
   logic [DW-1:0] env_d;
   int            env_beats;
   int            corrupt_at;
   logic [DW-1:0] corrupt_val;
   bit            force_full, force_empty;

   // reference model: write/beat indices of the tagged pair
   int            m_wr, m_rd, m_oidx, m_didx, m_bc;
   logic [DW-1:0] m_odata, m_oout;
   bit            m_oout_v, m_done, m_check;

   int cyc = 0;
   int last_valid_cyc, first_done_cyc;
   logic [DW-1:0] pool [3];

   typedef struct {
      bit            rst, v, full, empty;
      logic [DW-1:0] data;
      bit            wen, ren;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic setin(input bit v, input logic [DW-1:0] d, input bit o, input bit s);
      bus.bmc_in_v    = v;
      bus.bmc_in_data = d;
      bus.orig_sel    = o;
      bus.dup_sel     = s;
   endtask

   task automatic env_drive();
      bus.dut_full      = force_full || (fq.size() >= FDEPTH);
      bus.dut_empty     = force_empty || (fq.size() == 0);
      bus.dut_valid_out = env_v;
      bus.dut_data_out  = env_d;
   endtask

   task automatic model_reset();
      m_wr = 0; m_rd = 0; m_oidx = -1; m_didx = -1; m_bc = 0;
      m_odata = '0; m_oout = '0; m_oout_v = 0; m_done = 0; m_check = 0;
   endtask

   task automatic env_edge();
      bit nv = 0;
      logic [DW-1:0] d = '0;
      if (rst_n && bus.dut_ren && fq.size() > 0) begin
         d = fq.pop_front();
         if (env_beats == corrupt_at) d = corrupt_val;
         env_beats++;
         nv = 1;
      end
      if (rst_n && bus.dut_wen) fq.push_back(bus.bmc_in_data);
      env_v = nv;
      env_d = d;
   endtask

   // One clock edge of the checker's rules: the k-th valid beat is the
   // read-back of the k-th accepted write.
   task automatic model_edge(input bit acc_m);
      bit done_pre = m_done;
      bit hit = 0;
      int idx;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (bus.dut_valid_out) begin
         idx = m_rd;
         if (m_rd < MAXC) m_rd++;
         if (!done_pre && m_oidx >= 0 && idx == m_oidx) begin
            m_oout = bus.dut_data_out; m_oout_v = 1;
         end
         if (!done_pre && m_didx >= 0 && idx == m_didx) begin
            m_done = 1; hit = 1;
            m_check = m_oout_v && (bus.dut_data_out == m_oout);
         end
      end
`ifdef AQED_BC_EN
      if (!done_pre && !hit && m_didx >= 0) begin
         if (m_bc == RB) begin m_done = 1; m_check = 0; end
         else m_bc++;
      end
`endif
      if (acc_m) begin
         if (m_oidx < 0) begin
            if (bus.orig_sel && m_wr < MAXC) begin
               m_oidx = m_wr; m_odata = bus.bmc_in_data;
            end
         end else if (m_didx < 0) begin
            if (bus.dup_sel && !bus.orig_sel && m_wr < MAXC && bus.bmc_in_data == m_odata) begin
               m_didx = m_wr; m_bc = 0;
            end
         end
         if (m_wr < MAXC) m_wr++;
      end
   endtask

   task automatic tick();
      bit acc_m, ren_m;
      @(negedge clk);
      acc_m = rst_n && bus.bmc_in_v && !bus.dut_full && !m_done;
      ren_m = rst_n && !bus.dut_empty && !m_done;
      chk("wen", bus.dut_wen, acc_m);
      chk("ren", bus.dut_ren, ren_m);
      chk("data_in", bus.dut_data_in, bus.bmc_in_data);
      chk("seq_ptr", bus.seq_pointer, m_wr);
      chk("done", bus.qed_done, m_done);
      if (m_done) chk("check", bus.qed_check, m_check);
      if (bus.dut_valid_out) last_valid_cyc = cyc;
      if (bus.qed_done && first_done_cyc < 0) first_done_cyc = cyc;
      env_edge();
      model_edge(acc_m);
      @(posedge clk);
      #1;
      env_drive();
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 0;
      setin(0, '0, 0, 0);
      force_full = 0; force_empty = 0; corrupt_at = -1; corrupt_val = '0;
      fq.delete(); env_v = 0; env_d = '0; env_beats = 0;
      model_reset();
      env_drive();
      tick(); tick();
      rst_n = 1;
      first_done_cyc = -1; last_valid_cyc = -1;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (first_done_cyc < 0 && n < budget) begin
         tick(); n++;
      end
      chk({name, "_reached"}, (first_done_cyc >= 0), 1);
   endtask

   task automatic run_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                           input bit dup_on_b);
      setin(1, a, 1, 0);        tick();
      setin(1, b, 0, dup_on_b); tick();
      setin(1, c, 0, 1);        tick();
      setin(0, '0, 0, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      pool[0] = 8'd5; pool[1] = 8'd7; pool[2] = 8'd9;
      //            rst v full empty data   wen ren
      tbl[0] = '{1, 1, 0, 0, 8'h5A, 1, 1};
      tbl[1] = '{1, 1, 1, 0, 8'h11, 0, 1};
      tbl[2] = '{1, 1, 0, 1, 8'hC3, 1, 0};
      tbl[3] = '{1, 0, 0, 0, 8'h22, 0, 1};
      tbl[4] = '{1, 1, 1, 1, 8'h33, 0, 0};
      tbl[5] = '{0, 1, 0, 0, 8'h44, 0, 0};
      tbl[6] = '{0, 0, 0, 0, 8'h55, 0, 0};
      tbl[7] = '{1, 0, 1, 1, 8'h66, 0, 0};

      // reset state
      rst_n = 0;
      setin(0, '0, 0, 0);
      fq.delete(); env_v = 0; env_d = '0; force_full = 0; force_empty = 0;
      env_drive();
      #1;
      chk("rst_done", bus.qed_done, 0);
      chk("rst_check", bus.qed_check, 0);
      chk("rst_seq", bus.seq_pointer, 0);
      do_reset();

      // combinational gating table (state IDLE)
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         rst_n = tbl[i].rst;
         setin(tbl[i].v, tbl[i].data, 0, 0);
         bus.dut_full = tbl[i].full;
         bus.dut_empty = tbl[i].empty;
         bus.dut_valid_out = 0;
         #1;
         chk($sformatf("tbl%0d_wen", i), bus.dut_wen, tbl[i].wen);
         chk($sformatf("tbl%0d_ren", i), bus.dut_ren, tbl[i].ren);
         chk($sformatf("tbl%0d_din", i), bus.dut_data_in, tbl[i].data);
      end
      do_reset();

      // T1: 5,7,5 identity -> match, done one cycle after third beat
      run_pair(8'd5, 8'd7, 8'd5, 0);
      wait_done("t1", 20);
      chk("t1_done", bus.qed_done, 1);
      chk("t1_check", bus.qed_check, 1);
      chk("t1_lat", first_done_cyc, last_valid_cyc + 1);
      setin(1, 8'd3, 0, 0);
      #2;
      chk("t1_sticky_wen", bus.dut_wen, 0);
      tick(); tick();
      chk("t1_sticky_done", bus.qed_done, 1);

      // T2: third beat corrupted to 6
      do_reset();
      corrupt_at = 2; corrupt_val = 8'd6;
      run_pair(8'd5, 8'd7, 8'd5, 0);
      wait_done("t2", 20);
      chk("t2_done", bus.qed_done, 1);
      chk("t2_check", bus.qed_check, 0);

      // T3: dup_sel on 9 ignored, dup_sel on later 5 taken
      do_reset();
      run_pair(8'd5, 8'd9, 8'd5, 1);
      wait_done("t3", 20);
      chk("t3_check", bus.qed_check, 1);

      // T4: full held for 4 cycles blocks writes
      do_reset();
      force_full = 1; env_drive();
      setin(1, 8'd4, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_wen_blocked", bus.dut_wen, 0);
         tick();
      end
      chk("t4_seq_held", bus.seq_pointer, 0);
      force_full = 0; env_drive();
      tick(); tick();
      chk("t4_seq_resume", bus.seq_pointer, 2);
      setin(0, '0, 0, 0);
      tick();

      // T5: reset while in DUP
      do_reset();
      force_empty = 1; env_drive();
      run_pair(8'd5, 8'd5, 8'd7, 1);
      chk("t5_seq_pre", bus.seq_pointer, 3);
      force_empty = 0; env_drive();
      setin(1, 8'd7, 0, 0);
      rst_n = 0;
      model_reset();
      #1;
      chk("t5_wen_low", bus.dut_wen, 0);
      chk("t5_ren_low", bus.dut_ren, 0);
      chk("t5_seq_low", bus.seq_pointer, 0);
      chk("t5_done_low", bus.qed_done, 0);
      tick();
      do_reset();
      chk("t5_seq_after", bus.seq_pointer, 0);
      run_pair(8'd9, 8'd9, 8'd1, 1);
      wait_done("t5", 20);
      chk("t5_check", bus.qed_check, 1);

      // T6: DUT stalls after the duplicate write
      do_reset();
      force_empty = 1; env_drive();
      setin(1, 8'd5, 1, 0); tick();
      setin(1, 8'd5, 0, 1); tick();
      setin(0, '0, 0, 0);
`ifdef AQED_BC_EN
      repeat (8) tick();
      chk("t6_done_early", bus.qed_done, 0);
      tick();
      chk("t6_done", bus.qed_done, 1);
      chk("t6_check", bus.qed_check, 0);
`else
      repeat (40) tick();
      chk("t6_wait_done", bus.qed_done, 0);
      force_empty = 0; env_drive();
      wait_done("t6", 20);
      chk("t6_check", bus.qed_check, 1);
`endif

      // T7: write counter saturation, no tags afterwards
      do_reset();
      setin(1, 8'd2, 0, 0);
      repeat (20) tick();
      chk("t7_sat", bus.seq_pointer, MAXC);
      setin(1, 8'd5, 1, 0); tick();
      setin(1, 8'd5, 0, 1); tick();
      setin(0, '0, 0, 0);
      repeat (10) tick();
      chk("t7_no_tag", bus.qed_done, 0);

      // randomized episodes against the model
      for (int ep = 0; ep < 30; ep++) begin
         do_reset();
         corrupt_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
         corrupt_val = pool[$urandom_range(0, 2)];
         for (int c = 0; c < 80; c++) begin
            force_full  = ($urandom_range(0, 7) == 0);
            force_empty = ($urandom_range(0, 5) == 0);
            env_drive();
            setin($urandom_range(0, 3) != 0, pool[$urandom_range(0, 2)],
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
